// File: rtl/video_mem_arbiter.sv
// Video memory arbiter: tile, sprite and CPU share one memory port.
// Raster-phase priority with a CPU starvation guard.
module video_mem_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int CPU_STARVE = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              t_req,
  input  logic [ADDR_W-1:0] t_addr,
  output logic              t_ack,
  input  logic              s_req,
  input  logic [ADDR_W-1:0] s_addr,
  output logic              s_ack,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_T    = 2'd1;
  localparam logic [1:0] G_S    = 2'd2;
  localparam logic [1:0] G_C    = 2'd3;

  localparam logic [3:0] STARVE_MAX = 4'(CPU_STARVE);

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              t_ack_q, t_ack_d;
  logic              s_ack_q, s_ack_d;
  logic              c_ack_q, c_ack_d;
  logic [3:0]        starve_q, starve_d;

  logic       t_m, s_m, c_m;
  logic [1:0] win;

  // A requester being acked this cycle is masked so it is not re-granted.
  assign t_m = t_req & ~t_ack_q;
  assign s_m = s_req & ~s_ack_q;
  assign c_m = c_req & ~c_ack_q;

  // Winner pick: starved CPU first, then the raster phase order.
  always_comb begin
    win = G_NONE;
    if (c_m && (starve_q == STARVE_MAX)) begin
      win = G_C;
    end else if (vblank) begin
      if (c_m)      win = G_C;
      else if (s_m) win = G_S;
      else if (t_m) win = G_T;
    end else if (hblank) begin
      if (s_m)      win = G_S;
      else if (t_m) win = G_T;
      else if (c_m) win = G_C;
    end else begin
      if (t_m)      win = G_T;
      else if (s_m) win = G_S;
      else if (c_m) win = G_C;
    end
  end

  // Next-state: grant and latch in IDLE, wait for completion in BUSY.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    t_ack_d  = 1'b0;
    s_ack_d  = 1'b0;
    c_ack_d  = 1'b0;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (win != G_NONE) begin
          state_d = BUSY;
          grant_d = win;
          we_d    = 1'b0;
          wdata_d = '0;
          unique case (win)
            G_T:     addr_d = t_addr;
            G_S:     addr_d = s_addr;
            default: begin
              addr_d  = c_addr;
              we_d    = c_we;
              wdata_d = c_wdata;
            end
          endcase
          if (win == G_C) begin
            starve_d = 4'd0;
          end else if (c_req && (starve_q < STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d = IDLE;
          rdata_d = mem_rdata;
          t_ack_d = (grant_q == G_T);
          s_ack_d = (grant_q == G_S);
          c_ack_d = (grant_q == G_C);
          grant_d = G_NONE;
          addr_d  = '0;
          we_d    = 1'b0;
          wdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!c_req) begin
      starve_d = 4'd0;
    end
  end

  // State and datapath registers, all cleared by async reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= G_NONE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      t_ack_q  <= 1'b0;
      s_ack_q  <= 1'b0;
      c_ack_q  <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      t_ack_q  <= t_ack_d;
      s_ack_q  <= s_ack_d;
      c_ack_q  <= c_ack_d;
      starve_q <= starve_d;
    end
  end

  assign mem_req   = (state_q == BUSY);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign grant     = grant_q;
  assign t_ack     = t_ack_q;
  assign s_ack     = s_ack_q;
  assign c_ack     = c_ack_q;

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Directed bench for video_mem_arbiter.
// Inputs driven and outputs sampled on the falling edge.
module tb_video_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hblank, vblank;
  logic        t_req, s_req, c_req, c_we;
  logic [19:0] t_addr, s_addr, c_addr;
  logic [15:0] c_wdata;
  logic        t_ack, s_ack, c_ack;
  logic [15:0] rdata;
  logic        mem_req, mem_we;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [1:0]  grant;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  video_mem_arbiter #(
    .ADDR_W(20),
    .DATA_W(16),
    .CPU_STARVE(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hblank(hblank),
    .vblank(vblank),
    .t_req(t_req),
    .t_addr(t_addr),
    .t_ack(t_ack),
    .s_req(s_req),
    .s_addr(s_addr),
    .s_ack(s_ack),
    .c_req(c_req),
    .c_we(c_we),
    .c_addr(c_addr),
    .c_wdata(c_wdata),
    .c_ack(c_ack),
    .rdata(rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .grant(grant)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait for mem_req, check owner, complete with data d, check ack.
  task automatic serve(input string tag,
                       input logic [1:0] exp_g,
                       input logic [15:0] d);
    int n;
    logic [2:0] exp_ack;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_grant"}, {30'd0, grant}, {30'd0, exp_g});
    case (exp_g)
      2'd1:    exp_ack = 3'b001;
      2'd2:    exp_ack = 3'b010;
      2'd3:    exp_ack = 3'b100;
      default: exp_ack = 3'b000;
    endcase
    mem_ack   = 1'b1;
    mem_rdata = d;
    @(negedge clk);
    mem_ack   = 1'b0;
    check({tag, "_ack"}, {29'd0, c_ack, s_ack, t_ack}, {29'd0, exp_ack});
    check({tag, "_rdata"}, {16'd0, rdata}, {16'd0, d});
    check({tag, "_gnt0"}, {30'd0, grant}, 32'd0);
  endtask

  task automatic drop_all();
    t_req = 1'b0;
    s_req = 1'b0;
    c_req = 1'b0;
    c_we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    hblank = 1'b0; vblank = 1'b0;
    t_req = 1'b0; s_req = 1'b0; c_req = 1'b0; c_we = 1'b0;
    t_addr = 20'h00100; s_addr = 20'h00200;
    c_addr = 20'h00300; c_wdata = 16'h0;
    mem_ack = 1'b0; mem_rdata = 16'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_acks", {29'd0, c_ack, s_ack, t_ack}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_mem_addr", {12'd0, mem_addr}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single tile read in active area
    t_req = 1'b1;
    @(negedge clk);
    check("t1_req_n1", {31'd0, mem_req}, 32'd1);
    check("t1_grant", {30'd0, grant}, 32'd1);
    check("t1_addr", {12'd0, mem_addr}, 32'h00100);
    check("t1_we", {31'd0, mem_we}, 32'd0);
    repeat (2) @(negedge clk);
    check("t1_hold", {31'd0, mem_req}, 32'd1);
    check("t1_noack", {31'd0, t_ack}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    @(negedge clk);
    mem_ack = 1'b0;
    t_req = 1'b0;
    check("t1_ack", {31'd0, t_ack}, 32'd1);
    check("t1_rdata", {16'd0, rdata}, 32'h1234);
    check("t1_grant0", {30'd0, grant}, 32'd0);
    check("t1_memreq0", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check("t1_ackpulse", {31'd0, t_ack}, 32'd0);

    // Starvation: T,S alternate 8 times, then C
    t_req = 1'b1; s_req = 1'b1; c_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve($sformatf("stv%0d", i), (i % 2 == 0) ? 2'd1 : 2'd2,
            16'h0A00 + 16'(i));
    end
    check("stv_cnt8", {28'd0, dut.starve_q}, 32'd8);
    serve("stv_c", 2'd3, 16'h0C0C);
    check("stv_cnt0", {28'd0, dut.starve_q}, 32'd0);
    drop_all();
    repeat (2) @(negedge clk);

    // Horizontal blank: sprite first
    hblank = 1'b1;
    t_req = 1'b1; s_req = 1'b1; c_req = 1'b1;
    serve("hb", 2'd2, 16'h5555);
    drop_all();
    repeat (2) @(negedge clk);

    // Vertical blank: CPU first
    hblank = 1'b0; vblank = 1'b1;
    t_req = 1'b1; s_req = 1'b1; c_req = 1'b1;
    serve("vb", 2'd3, 16'h6666);
    drop_all();
    vblank = 1'b0;
    repeat (2) @(negedge clk);

    // CPU write
    c_req = 1'b1; c_we = 1'b1;
    c_addr = 20'h12345; c_wdata = 16'hBEEF;
    @(negedge clk);
    check("cw_we", {31'd0, mem_we}, 32'd1);
    check("cw_addr", {12'd0, mem_addr}, 32'h12345);
    check("cw_wdata", {16'd0, mem_wdata}, 32'hBEEF);
    repeat (2) @(negedge clk);
    check("cw_we_hold", {31'd0, mem_we}, 32'd1);
    check("cw_wd_hold", {16'd0, mem_wdata}, 32'hBEEF);
    serve("cw", 2'd3, 16'h0000);
    drop_all();
    repeat (2) @(negedge clk);

    // Phase change while tile is in flight
    t_req = 1'b1;
    @(negedge clk);
    check("ph_grant_t", {30'd0, grant}, 32'd1);
    s_req = 1'b1;
    hblank = 1'b1;
    repeat (2) @(negedge clk);
    check("ph_still_t", {30'd0, grant}, 32'd1);
    check("ph_addr_t", {12'd0, mem_addr}, 32'h00100);
    serve("ph_t", 2'd1, 16'h7777);
    t_req = 1'b0;
    serve("ph_s", 2'd2, 16'h8888);
    drop_all();
    hblank = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during a busy transaction
    t_req = 1'b1;
    @(negedge clk);
    check("rb_busy", {31'd0, mem_req}, 32'd1);
    reset_n = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    #1;
    check("rb_req0", {31'd0, mem_req}, 32'd0);
    check("rb_acks0", {29'd0, c_ack, s_ack, t_ack}, 32'd0);
    check("rb_grant0", {30'd0, grant}, 32'd0);
    @(negedge clk);
    check("rb_noack", {29'd0, c_ack, s_ack, t_ack}, 32'd0);
    mem_ack = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("rb_regrant", {31'd0, mem_req}, 32'd1);
    check("rb_grant_t", {30'd0, grant}, 32'd1);
    serve("rb_t", 2'd1, 16'hAAAA);
    drop_all();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
